// File: rtl/parity_pkg.sv
// Shared types and helpers for the UART parity engine: mode/state encodings,
// data-length clamping and the final parity selection.
package parity_pkg;

   typedef enum logic [1:0] {
      PAR_EVEN  = 2'b00,
      PAR_ODD   = 2'b01,
      PAR_MARK  = 2'b10,
      PAR_SPACE = 2'b11
   } parity_mode_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   // A zero length still frames one data bit; anything longer than the
   // datapath is cut down to the full datapath width.
   function automatic int clamp_len(input int len, input int max_w);
      if (len < 1)
         return 1;
      else if (len > max_w)
         return max_w;
      else
         return len;
   endfunction

   function automatic logic parity_of(input parity_mode_t mode, input logic en,
                                      input logic acc);
      logic p;
      p = 1'b0;
      if (en) begin
         case (mode)
            PAR_EVEN:  p = acc;
            PAR_ODD:   p = ~acc;
            PAR_MARK:  p = 1'b1;
            PAR_SPACE: p = 1'b0;
            default:   p = 1'b0;
         endcase
      end
      return p;
   endfunction

endpackage

// File: rtl/par_err_counter.sv
// Saturating parity-error counter; a clear coinciding with an increment
// leaves a count of one so that error is not lost.
module par_err_counter #(
   parameter int CNT_W = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= inc ? CNT_W'(1) : '0;
      end else if (inc && (count_q != {CNT_W{1'b1}})) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign count = count_q;

endmodule

// File: rtl/parity_gen_check.sv
// UART parity generator/checker with valid/ready on both sides and a serial
// bit-per-cycle accumulator; define PARITY_FAST_EN for single-cycle parity.
module parity_gen_check
   import parity_pkg::*;
#(
   parameter int MAX_WIDTH = 9,
   parameter int LEN_W     = $clog2(MAX_WIDTH + 1),
   parameter int CNT_W     = 8
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 parity_enable,
   input  logic [1:0]           parity_mode,
   input  logic                 chk_mode,
   input  logic [LEN_W-1:0]     cfg_len,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [MAX_WIDTH-1:0] in_data,
   input  logic                 in_par_bit,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 parity,
   output logic                 par_err,
   input  logic                 err_clr,
   output logic [CNT_W-1:0]     err_count,
   output logic                 busy
);

   state_t               state_q;
   logic [MAX_WIDTH-1:0] shreg_q;
   logic [LEN_W-1:0]     cnt_q;
   logic                 acc_q;
   logic                 en_q;
   parity_mode_t         mode_q;
   logic                 chk_q;
   logic                 pbit_q;
   logic                 out_valid_q;
   logic                 parity_q;
   logic                 par_err_q;

   logic [LEN_W-1:0]     len_d;
   logic [MAX_WIDTH-1:0] data_masked_d;
   logic                 acc_d;
   logic                 calc_par_d;
   logic                 err_inc_d;

   // Bits at or beyond the effective length are zeroed once at accept, so the
   // shift register and the fast reduction never see them.
   for (genvar gi = 0; gi < MAX_WIDTH; gi++) begin : g_mask
      assign data_masked_d[gi] = in_data[gi] & (LEN_W'(gi) < len_d);
   end

   always_comb begin
      len_d      = LEN_W'(clamp_len(int'(cfg_len), MAX_WIDTH));
      acc_d      = acc_q ^ shreg_q[0];
      calc_par_d = parity_of(mode_q, 1'b1, acc_d);
   end

`ifdef PARITY_FAST_EN
   logic fast_par_d;
   always_comb begin
      fast_par_d = parity_of(parity_mode_t'(parity_mode), 1'b1, ^data_masked_d);
   end
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         shreg_q     <= '0;
         cnt_q       <= '0;
         acc_q       <= 1'b0;
         en_q        <= 1'b0;
         mode_q      <= PAR_EVEN;
         chk_q       <= 1'b0;
         pbit_q      <= 1'b0;
         out_valid_q <= 1'b0;
         parity_q    <= 1'b0;
         par_err_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  shreg_q <= data_masked_d;
                  cnt_q   <= len_d;
                  acc_q   <= 1'b0;
                  en_q    <= parity_enable;
                  mode_q  <= parity_mode_t'(parity_mode);
                  chk_q   <= chk_mode;
                  pbit_q  <= in_par_bit;
                  if (!parity_enable) begin
                     state_q     <= ST_DONE;
                     out_valid_q <= 1'b1;
                     parity_q    <= 1'b0;
                     par_err_q   <= 1'b0;
                  end else begin
`ifdef PARITY_FAST_EN
                     state_q     <= ST_DONE;
                     out_valid_q <= 1'b1;
                     parity_q    <= fast_par_d;
                     par_err_q   <= chk_mode && (fast_par_d != in_par_bit);
`else
                     state_q     <= ST_CALC;
`endif
                  end
               end
            end
            ST_CALC: begin
               acc_q   <= acc_d;
               shreg_q <= shreg_q >> 1;
               cnt_q   <= cnt_q - LEN_W'(1);
               if (cnt_q == LEN_W'(1)) begin
                  state_q     <= ST_DONE;
                  out_valid_q <= 1'b1;
                  parity_q    <= calc_par_d;
                  par_err_q   <= chk_q && en_q && (calc_par_d != pbit_q);
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_q     <= ST_IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign err_inc_d = out_valid_q && out_ready && par_err_q;

   par_err_counter #(
      .CNT_W (CNT_W)
   ) u_err_counter (
      .CLK   (CLK),
      .RST   (RST),
      .inc   (err_inc_d),
      .clr   (err_clr),
      .count (err_count)
   );

   assign in_ready  = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign out_valid = out_valid_q;
   assign parity    = parity_q;
   assign par_err   = par_err_q;

endmodule

// File: tb/tb_parity_gen_check.sv
// Self-checking bench for parity_gen_check: directed vector table, corner
// sequences (stall, clear, reset abort) and random words against a model.
module tb_parity_gen_check;

   localparam int MAX_WIDTH = 9;
   localparam int LEN_W     = 4;
   localparam int CNT_W     = 2;
`ifdef PARITY_FAST_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic                 CLK = 1'b0;
   logic                 RST = 1'b1;
   logic                 parity_enable = 1'b0;
   logic [1:0]           parity_mode = 2'b00;
   logic                 chk_mode = 1'b0;
   logic [LEN_W-1:0]     cfg_len = '0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic [MAX_WIDTH-1:0] in_data = '0;
   logic                 in_par_bit = 1'b0;
   logic                 out_valid;
   logic                 out_ready = 1'b0;
   logic                 parity;
   logic                 par_err;
   logic                 err_clr = 1'b0;
   logic [CNT_W-1:0]     err_count;
   logic                 busy;

   int n_checks = 0;
   int n_pass   = 0;
   int mdl_cnt  = 0;

   always #5 CLK = ~CLK;

   parity_gen_check #(
      .MAX_WIDTH (MAX_WIDTH),
      .LEN_W     (LEN_W),
      .CNT_W     (CNT_W)
   ) dut (
      .CLK           (CLK),
      .RST           (RST),
      .parity_enable (parity_enable),
      .parity_mode   (parity_mode),
      .chk_mode      (chk_mode),
      .cfg_len       (cfg_len),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .in_par_bit    (in_par_bit),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .parity        (parity),
      .par_err       (par_err),
      .err_clr       (err_clr),
      .err_count     (err_count),
      .busy          (busy)
   );

   typedef struct {
      logic       en;
      logic [1:0] mode;
      logic       chk;
      logic [3:0] len;
      logic [8:0] data;
      logic       pbit;
      logic       exp_par;
      logic       exp_err;
   } vec_t;

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual == expected)
         n_pass++;
      else
         $display("FAIL %s: got %0d expected %0d", name, actual, expected);
   endtask

   function automatic int eff_len(input logic [3:0] len);
      if (len == 0) return 1;
      if (len > MAX_WIDTH) return MAX_WIDTH;
      return int'(len);
   endfunction

   // Parity from the rules: count the ones in the first L data bits.
   function automatic logic ref_par(input logic en, input logic [1:0] mode,
                                    input logic [3:0] len, input logic [8:0] data);
      int ones;
      if (!en) return 1'b0;
      ones = 0;
      for (int i = 0; i < eff_len(len); i++) ones += int'(data[i]);
      case (mode)
         2'd0:    return logic'(ones % 2);
         2'd1:    return logic'(1 - ones % 2);
         2'd2:    return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic int ref_lat(input logic en, input logic [3:0] len);
      if (FAST || !en) return 1;
      return eff_len(len) + 1;
   endfunction

   function automatic void mdl_update(input logic clr, input logic inc);
      if (clr)
         mdl_cnt = inc ? 1 : 0;
      else if (inc && mdl_cnt < (1 << CNT_W) - 1)
         mdl_cnt++;
   endfunction

   // Presents one word at a negedge, scrambles config while it is in flight,
   // stalls the result for `hold` cycles, then takes it.
   task automatic run_word(input string tag, input logic en, input logic [1:0] mode,
                           input logic chk, input logic [3:0] len, input logic [8:0] data,
                           input logic pbit, input int hold, input logic clr_at_hs);
      int lat;
      logic ep, ee;
      ep = ref_par(en, mode, len, data);
      ee = chk && en && (ep != pbit);
      check({tag, ".in_ready_idle"}, int'(in_ready), 1);
      parity_enable = en; parity_mode = mode; chk_mode = chk;
      cfg_len = len; in_data = data; in_par_bit = pbit; in_valid = 1'b1;
      @(posedge CLK);
      lat = 1;
      @(negedge CLK);
      in_valid = 1'b0;
      parity_enable = 1'($urandom); parity_mode = 2'($urandom); chk_mode = 1'($urandom);
      cfg_len = 4'($urandom); in_data = 9'($urandom); in_par_bit = 1'($urandom);
      while (!out_valid && lat < 40) begin
         @(posedge CLK);
         lat++;
         @(negedge CLK);
      end
      check({tag, ".latency"}, lat, ref_lat(en, len));
      check({tag, ".parity"}, int'(parity), int'(ep));
      check({tag, ".par_err"}, int'(par_err), int'(ee));
      check({tag, ".in_ready_busy"}, int'(in_ready), 0);
      for (int h = 0; h < hold; h++) begin
         @(posedge CLK);
         @(negedge CLK);
         check({tag, ".stall_valid"}, int'(out_valid), 1);
         check({tag, ".stall_parity"}, int'(parity), int'(ep));
         check({tag, ".stall_in_ready"}, int'(in_ready), 0);
      end
      err_clr = clr_at_hs;
      out_ready = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      out_ready = 1'b0;
      err_clr = 1'b0;
      mdl_update(clr_at_hs, ee);
      check({tag, ".valid_drop"}, int'(out_valid), 0);
      check({tag, ".err_count"}, int'(err_count), mdl_cnt);
      $display("word %s en=%0d mode=%0d chk=%0d len=%0d data=%03h pbit=%0d -> par=%0d err=%0d lat=%0d cnt=%0d",
               tag, en, mode, chk, len, data, pbit, parity, par_err, lat, err_count);
   endtask

   vec_t tbl[12];

   initial begin
      tbl[0]  = '{1'b1, 2'd0, 1'b0, 4'd8,  9'h0B3, 1'b0, 1'b1, 1'b0};
      tbl[1]  = '{1'b1, 2'd1, 1'b0, 4'd7,  9'h1FF, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 2'd0, 1'b1, 4'd8,  9'h003, 1'b1, 1'b0, 1'b1};
      tbl[3]  = '{1'b1, 2'd0, 1'b1, 4'd8,  9'h003, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 2'd2, 1'b0, 4'd5,  9'h015, 1'b0, 1'b1, 1'b0};
      tbl[5]  = '{1'b1, 2'd3, 1'b0, 4'd5,  9'h015, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 2'd0, 1'b1, 4'd5,  9'h001, 1'b1, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 2'd0, 1'b0, 4'd0,  9'h003, 1'b0, 1'b1, 1'b0};
      tbl[8]  = '{1'b1, 2'd0, 1'b0, 4'd12, 9'h100, 1'b0, 1'b1, 1'b0};
      tbl[9]  = '{1'b1, 2'd1, 1'b1, 4'd9,  9'h1FF, 1'b1, 1'b0, 1'b1};
      tbl[10] = '{1'b1, 2'd2, 1'b1, 4'd3,  9'h000, 1'b0, 1'b1, 1'b1};
      tbl[11] = '{1'b1, 2'd3, 1'b1, 4'd3,  9'h007, 1'b1, 1'b0, 1'b1};

      repeat (3) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      check("reset.in_ready", int'(in_ready), 1);
      check("reset.out_valid", int'(out_valid), 0);
      check("reset.parity", int'(parity), 0);
      check("reset.par_err", int'(par_err), 0);
      check("reset.err_count", int'(err_count), 0);
      check("reset.busy", int'(busy), 0);

      // Hand-derived expectations also cross-checked against the model.
      for (int i = 0; i < 12; i++) begin
         check($sformatf("tbl%0d.ref_par", i),
               int'(ref_par(tbl[i].en, tbl[i].mode, tbl[i].len, tbl[i].data)),
               int'(tbl[i].exp_par));
         check($sformatf("tbl%0d.ref_err", i),
               int'(tbl[i].chk && tbl[i].en && (tbl[i].exp_par != tbl[i].pbit)),
               int'(tbl[i].exp_err));
         run_word($sformatf("tbl%0d", i), tbl[i].en, tbl[i].mode, tbl[i].chk,
                  tbl[i].len, tbl[i].data, tbl[i].pbit, (i == 0) ? 10 : 0, 1'b0);
      end
      check("saturated", int'(err_count), 3);

      run_word("clr_plus_inc", 1'b1, 2'd0, 1'b1, 4'd8, 9'h003, 1'b1, 0, 1'b1);
      check("clr_plus_inc.count_one", int'(err_count), 1);

      err_clr = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      err_clr = 1'b0;
      mdl_update(1'b1, 1'b0);
      check("clr_alone", int'(err_count), 0);
      $display("clr alone -> cnt=%0d", err_count);

      run_word("pre_rst", 1'b1, 2'd1, 1'b1, 4'd4, 9'h000, 1'b0, 0, 1'b0);
      check("pre_rst.count", int'(err_count), 1);

      // Reset lands three cycles into the serial calculation.
      parity_enable = 1'b1; parity_mode = 2'd0; chk_mode = 1'b1;
      cfg_len = 4'd8; in_data = 9'h001; in_par_bit = 1'b0; in_valid = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      in_valid = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      mdl_cnt = 0;
      check("abort.out_valid", int'(out_valid), 0);
      check("abort.err_count", int'(err_count), 0);
      check("abort.in_ready", int'(in_ready), 1);
      check("abort.busy", int'(busy), 0);
      begin
         int seen;
         seen = 0;
         repeat (12) begin
            @(posedge CLK);
            @(negedge CLK);
            seen += int'(out_valid);
         end
         check("abort.no_result", seen, 0);
      end
      $display("reset abort -> out_valid=%0d cnt=%0d in_ready=%0d", out_valid, err_count, in_ready);

      for (int r = 0; r < 150; r++) begin
         run_word($sformatf("rnd%0d", r), 1'($urandom), 2'($urandom), 1'($urandom),
                  4'($urandom), 9'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
                  ($urandom_range(0, 7) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
